operand_fetch_stage: RTL

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/operand_fetch_stage_pkg.sv | 13 +
 rtl/operand_fetch_stage_bypass_mux.sv | 55 +++++
 rtl/operand_fetch_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared word and register-address types plus the producer-match helper used by the operand fetch stage.
package operand_fetch_stage_pkg;

    typedef logic [31:0] Word;
    typedef logic [4:0]  RegAddress;

    localparam RegAddress ZERO_REG = 5'd0;

    function automatic logic addr_hit(input logic we, input RegAddress producer, input RegAddress src);
        return we && (producer == src);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_bypass_mux.sv
// Resolves one source operand against the EX/MEM/WB producers and reports whether it must stall.
// FORWARDING_EN selects full bypassing; otherwise any in-flight producer of the source stalls.
module bypass_mux
    import operand_fetch_stage_pkg::*;
(
    input  RegAddress src_addr,
    input  Word       rf_data,
    input  logic      ex_we,
    input  logic      ex_is_load,
    input  RegAddress ex_rd,
    input  Word       ex_data,
    input  logic      mem_we,
    input  RegAddress mem_rd,
    input  Word       mem_data,
    input  logic      wb_we,
    input  RegAddress wb_rd,
    input  Word       wb_data,
    output Word       operand,
    output logic      stall_req
);

    logic src_zero;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign src_zero = (src_addr == ZERO_REG);
    assign ex_hit   = addr_hit(ex_we, ex_rd, src_addr);
    assign mem_hit  = addr_hit(mem_we, mem_rd, src_addr);
    assign wb_hit   = addr_hit(wb_we, wb_rd, src_addr);

`ifdef FORWARDING_EN
    // Youngest producer wins; a load in EX has no data yet, so it stalls instead.
    always_comb begin
        operand = rf_data;
        if (src_zero)
            operand = '0;
        else if (ex_hit && !ex_is_load)
            operand = ex_data;
        else if (mem_hit)
            operand = mem_data;
        else if (wb_hit)
            operand = wb_data;
    end

    assign stall_req = !src_zero && ex_hit && ex_is_load;
`else
    logic unused_data;
    assign unused_data = ^{ex_data, mem_data, wb_data, ex_is_load};

    assign operand   = src_zero ? '0 : rf_data;
    assign stall_req = !src_zero && (ex_hit || mem_hit || wb_hit);
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch pipeline stage: register file read, hazard stall and one-deep output register.
// Bypassing is enabled with the FORWARDING_EN macro.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    input  logic      in_valid,
    output logic      in_ready,
    input  RegAddress in_rs1,
    input  RegAddress in_rs2,
    input  RegAddress in_rd,
    input  logic      in_rd_we,
    input  logic      in_is_load,
    input  Word       in_pc,
    input  Word       in_imm,
    output RegAddress rf_addr1,
    output RegAddress rf_addr2,
    input  Word       rf_data1,
    input  Word       rf_data2,
    input  Word       ex_result,
    input  logic      mem_we,
    input  RegAddress mem_rd,
    input  Word       mem_data,
    input  logic      wb_we,
    input  RegAddress wb_rd,
    input  Word       wb_data,
    output logic      out_valid,
    input  logic      out_ready,
    output Word       out_rs1_val,
    output Word       out_rs2_val,
    output RegAddress out_rd,
    output logic      out_rd_we,
    output logic      out_is_load,
    output Word       out_pc,
    output Word       out_imm,
    output Word       stall_cycles
);

    Word  rs1_val;
    Word  rs2_val;
    logic stall1;
    logic stall2;
    logic ex_we;
    logic hazard;
    logic capture;

    assign rf_addr1 = in_rs1;
    assign rf_addr2 = in_rs2;

    // The instruction in the output register is the EX-stage producer.
    assign ex_we = out_valid && out_rd_we;

    bypass_mux u_bypass_rs1 (
        .src_addr  (in_rs1),
        .rf_data   (rf_data1),
        .ex_we     (ex_we),
        .ex_is_load(out_is_load),
        .ex_rd     (out_rd),
        .ex_data   (ex_result),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .operand   (rs1_val),
        .stall_req (stall1)
    );

    bypass_mux u_bypass_rs2 (
        .src_addr  (in_rs2),
        .rf_data   (rf_data2),
        .ex_we     (ex_we),
        .ex_is_load(out_is_load),
        .ex_rd     (out_rd),
        .ex_data   (ex_result),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .operand   (rs2_val),
        .stall_req (stall2)
    );

    assign hazard   = in_valid && (stall1 || stall2);
    assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    // Output register: reset beats flush, flush beats capture, capture beats drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_is_load <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
            out_is_load <= in_is_load;
            out_pc      <= in_pc;
            out_imm     <= in_imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (hazard && !flush)
            stall_cycles <= stall_cycles + 32'd1;
    end

endmodule
